// File: rtl/unsort4_pkg.sv
// Shared constants and FSM state encoding for the unsort4 block.
package unsort4_pkg;

    localparam int unsigned DW_DEFAULT = 4;  // default data width per element
    localparam int unsigned N_ELEM     = 4;  // elements per tuple (fixed)
    localparam int unsigned IDX_W      = 2;  // width of an element position

    typedef enum logic [0:0] {
        IDLE = 1'b0,
        SEND = 1'b1
    } state_e;

endpackage

// File: rtl/unsort4_chk.sv
// Tuple validator for unsort4: the indices must form a permutation of 0..3
// and the values must be in ascending order. Combinational only.
// Compiled only when UNSORT4_CHECK_EN is defined.
`ifdef UNSORT4_CHECK_EN
module unsort4_chk
    import unsort4_pkg::*;
#(
    parameter int DW = DW_DEFAULT
) (
    input  logic [DW-1:0]    ra,
    input  logic [DW-1:0]    rb,
    input  logic [DW-1:0]    rc,
    input  logic [DW-1:0]    rd,
    input  logic [IDX_W-1:0] ia,
    input  logic [IDX_W-1:0] ib,
    input  logic [IDX_W-1:0] ic,
    input  logic [IDX_W-1:0] id,
    output logic             ok
);

    logic [N_ELEM-1:0] seen;
    logic              perm_ok;
    logic              order_ok;

    // Mark every position named by an index; a permutation marks all four.
    always_comb begin
        seen     = '0;
        seen[ia] = 1'b1;
        seen[ib] = 1'b1;
        seen[ic] = 1'b1;
        seen[id] = 1'b1;
    end

    assign perm_ok  = &seen;
    assign order_ok = (ra <= rb) && (rb <= rc) && (rc <= rd);
    assign ok       = perm_ok && order_ok;

endmodule
`endif

// File: rtl/unsort4.sv
// unsort4: takes a sorted 4-tuple plus the original position of each value,
// scatters it back into a 4-entry buffer and streams the elements out in
// original order (position 0..3) over a valid/ready interface.
// Optional: define UNSORT4_CHECK_EN to validate tuples and pulse err on a
// rejected one (the tuple is then dropped).
module unsort4
    import unsort4_pkg::*;
#(
    parameter int DW = DW_DEFAULT,
    parameter int N  = N_ELEM
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [DW-1:0]    ra,
    input  logic [DW-1:0]    rb,
    input  logic [DW-1:0]    rc,
    input  logic [DW-1:0]    rd,
    input  logic [IDX_W-1:0] ia,
    input  logic [IDX_W-1:0] ib,
    input  logic [IDX_W-1:0] ic,
    input  logic [IDX_W-1:0] id,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [DW-1:0]    out_data,
    output logic [IDX_W-1:0] out_idx,
    output logic             out_last,
    output logic             err
);

    localparam logic [IDX_W-1:0] LAST = IDX_W'(N - 1);

    state_e           state_q, state_d;
    logic [IDX_W-1:0] cnt_q, cnt_d;
    logic [DW-1:0]    buf_q [N_ELEM];
    logic [DW-1:0]    buf_d [N_ELEM];
    logic             rdy_q;
    logic             last_elem;
    logic             accept;
    logic             xfer;
    logic             tuple_ok;
    logic             take;

    assign last_elem = (cnt_q == LAST);
    assign out_valid = (state_q == SEND);
    assign xfer      = out_valid && out_ready;

    // rdy_q keeps in_ready low during reset and until the first edge after release.
    assign in_ready = rdy_q && ((state_q == IDLE) ||
                                (state_q == SEND && last_elem && out_ready));
    assign accept   = in_valid && in_ready;
    assign take     = accept && tuple_ok;

    assign out_data = out_valid ? buf_q[cnt_q] : '0;
    assign out_idx  = out_valid ? cnt_q : '0;
    assign out_last = out_valid && last_elem;

`ifdef UNSORT4_CHECK_EN
    logic err_q;

    unsort4_chk #(
        .DW (DW)
    ) u_chk (
        .ra (ra),
        .rb (rb),
        .rc (rc),
        .rd (rd),
        .ia (ia),
        .ib (ib),
        .ic (ic),
        .id (id),
        .ok (tuple_ok)
    );

    // One-cycle error pulse following an accepted but invalid tuple.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            err_q <= 1'b0;
        end else begin
            err_q <= accept && !tuple_ok;
        end
    end

    assign err = err_q;
`else
    assign tuple_ok = 1'b1;
    assign err      = 1'b0;
`endif

    // FSM and element counter; a new tuple at the last handshake restarts at 0.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        if (xfer) begin
            if (last_elem) begin
                state_d = IDLE;
                cnt_d   = '0;
            end else begin
                cnt_d = cnt_q + 1'b1;
            end
        end
        if (take) begin
            state_d = SEND;
            cnt_d   = '0;
        end
    end

    // Scatter write; later writes win so duplicate indices favour rd > rc > rb > ra.
    always_comb begin
        for (int k = 0; k < int'(N_ELEM); k++) begin
            buf_d[k] = buf_q[k];
        end
        if (take) begin
            buf_d[ia] = ra;
            buf_d[ib] = rb;
            buf_d[ic] = rc;
            buf_d[id] = rd;
        end
    end

    // State, counter and buffer registers.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            rdy_q   <= 1'b0;
            for (int k = 0; k < int'(N_ELEM); k++) begin
                buf_q[k] <= '0;
            end
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            rdy_q   <= 1'b1;
            for (int k = 0; k < int'(N_ELEM); k++) begin
                buf_q[k] <= buf_d[k];
            end
        end
    end

endmodule

// File: tb/tb_unsort4.sv
// Self-checking bench for unsort4: table-driven tuples, hand-written
// back-pressure / reset / check-path sequences and a random stream,
// all scored through an expected-output queue.
module tb_unsort4;

    logic       clk;
    logic       rst_n;
    logic       in_valid;
    logic       in_ready;
    logic [3:0] ra, rb, rc, rd;
    logic [1:0] ia, ib, ic, id;
    logic       out_valid;
    logic       out_ready;
    logic [3:0] out_data;
    logic [1:0] out_idx;
    logic       out_last;
    logic       err;

    unsort4 #(
        .DW (4),
        .N  (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .ra        (ra),
        .rb        (rb),
        .rc        (rc),
        .rd        (rd),
        .ia        (ia),
        .ib        (ib),
        .ic        (ic),
        .id        (id),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_idx   (out_idx),
        .out_last  (out_last),
        .err       (err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic [3:0][3:0] r;
        logic [3:0][1:0] ix;
        logic [3:0][3:0] e;
    } vec_t;

    typedef struct packed {
        logic [1:0] idx;
        logic [3:0] data;
        logic       last;
    } exp_t;

    exp_t q[$];
    int   nvec = 0;
    int   nerr = 0;
    int   cyc  = 0;
    bit   rand_bp = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        nvec++;
        if (act !== exp) begin
            nerr++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Scoreboard: every transfer pops one expected element.
    always @(negedge clk) begin
        exp_t e;
        if (rst_n && out_valid && out_ready) begin
            if (q.size() == 0) begin
                nvec++;
                nerr++;
                $display("FAIL unexpected_output: got idx %0d data %0d, expected none",
                         out_idx, out_data);
            end else begin
                e = q.pop_front();
                check("out_idx", 32'(out_idx), 32'(e.idx));
                check("out_data", 32'(out_data), 32'(e.data));
                check("out_last", 32'(out_last), 32'(e.last));
            end
        end
    end

    // Random back-pressure during the random phase.
    always @(posedge clk) begin
        if (rand_bp) begin
            #1;
            out_ready = ($urandom % 4) != 0;
        end
    end

    task automatic push4(input logic [3:0][3:0] e);
        for (int k = 0; k < 4; k++) begin
            q.push_back({2'(k), e[k], (k == 3)});
        end
    endtask

    // Present a tuple and hold it until accepted; returns at accept edge + 1.
    task automatic send(input logic [3:0][3:0] r, input logic [3:0][1:0] ix,
                        output int acc_cyc);
        bit rdy;
        bit ok;
        ok       = 1'b0;
        acc_cyc  = -1;
        in_valid = 1'b1;
        ra = r[0]; rb = r[1]; rc = r[2]; rd = r[3];
        ia = ix[0]; ib = ix[1]; ic = ix[2]; id = ix[3];
        for (int k = 0; k < 40 && !ok; k++) begin
            @(negedge clk);
            rdy = in_ready;
            @(posedge clk);
            #1;
            if (rdy) begin
                ok      = 1'b1;
                acc_cyc = cyc;
            end
        end
        if (!ok) begin
            nvec++;
            nerr++;
            $display("FAIL accept_timeout: got no accept, expected accept within 40 cycles");
        end
    endtask

    task automatic drain();
        for (int k = 0; k < 80 && q.size() != 0; k++) @(negedge clk);
        check("drain", 32'(q.size()), 32'd0);
        @(posedge clk);
        #1;
    endtask

    function automatic vec_t mkv(input int r0, input int r1, input int r2, input int r3,
                                 input int i0, input int i1, input int i2, input int i3,
                                 input int e0, input int e1, input int e2, input int e3);
        vec_t v;
        v.r[0] = r0[3:0]; v.r[1] = r1[3:0]; v.r[2] = r2[3:0]; v.r[3] = r3[3:0];
        v.ix[0] = i0[1:0]; v.ix[1] = i1[1:0]; v.ix[2] = i2[1:0]; v.ix[3] = i3[1:0];
        v.e[0] = e0[3:0]; v.e[1] = e1[3:0]; v.e[2] = e2[3:0]; v.e[3] = e3[3:0];
        return v;
    endfunction

    initial begin
        vec_t            tbl[5];
        vec_t            basic;
        int              acc, prev_acc;
        logic [3:0]      orig[4];
        logic [3:0]      v[4];
        logic [1:0]      vi[4];
        logic [3:0]      tv;
        logic [1:0]      ti;
        logic [3:0][3:0] pr;
        logic [3:0][1:0] pi;
        logic [3:0][3:0] pe;

        tbl[0] = mkv(1, 3, 7, 9,   2, 0, 3, 1,  3, 9, 1, 7);
        tbl[1] = mkv(0, 0, 5, 14,  3, 2, 1, 0,  14, 5, 0, 0);
        tbl[2] = mkv(2, 4, 6, 8,   0, 1, 2, 3,  2, 4, 6, 8);
        tbl[3] = mkv(1, 1, 15, 15, 1, 3, 0, 2,  15, 1, 15, 1);
        tbl[4] = mkv(0, 7, 7, 12,  3, 0, 2, 1,  7, 12, 7, 0);
        basic  = tbl[0];

        // Reset state.
        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
        ra = '0; rb = '0; rc = '0; rd = '0; ia = '0; ib = '0; ic = '0; id = '0;
        #3;
        check("rst_out_valid", 32'(out_valid), 32'd0);
        check("rst_in_ready", 32'(in_ready), 32'd0);
        check("rst_out_data", 32'(out_data), 32'd0);
        check("rst_out_idx", 32'(out_idx), 32'd0);
        check("rst_out_last", 32'(out_last), 32'd0);
        check("rst_err", 32'(err), 32'd0);
        repeat (2) @(posedge clk);
        #1;
        check("rst_in_ready_held", 32'(in_ready), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        check("in_ready_before_edge", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        check("in_ready_after_edge", 32'(in_ready), 32'd1);

        // Table: continuous in_valid, so tuples must hand off every 4 cycles.
        prev_acc = 0;
        for (int i = 0; i < 5; i++) begin
            send(tbl[i].r, tbl[i].ix, acc);
            push4(tbl[i].e);
            if (i == 0) begin
                check("latency_valid", 32'(out_valid), 32'd1);
                check("latency_idx", 32'(out_idx), 32'd0);
            end else begin
                check("b2b_spacing", 32'(acc - prev_acc), 32'd4);
            end
            prev_acc = acc;
        end
        in_valid = 1'b0;
        drain();

        // Back-pressure at cnt=1 for 3 cycles.
        send(basic.r, basic.ix, acc);
        push4(basic.e);
        in_valid = 1'b1;  // keep offering so in_ready=0 is observable
        @(posedge clk);
        #1;
        out_ready = 1'b0;
        for (int k = 0; k < 3; k++) begin
            @(negedge clk);
            check("bp_valid", 32'(out_valid), 32'd1);
            check("bp_data", 32'(out_data), 32'd9);
            check("bp_idx", 32'(out_idx), 32'd1);
            check("bp_in_ready", 32'(in_ready), 32'd0);
        end
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        out_ready = 1'b1;
        drain();

`ifdef UNSORT4_CHECK_EN
        // Duplicate index and unsorted values are dropped with an err pulse.
        pi = {2'd3, 2'd2, 2'd0, 2'd0};
        send(basic.r, pi, acc);
        in_valid = 1'b0;
        check("dup_err", 32'(err), 32'd1);
        check("dup_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("dup_err_clear", 32'(err), 32'd0);
        check("dup_still_idle", 32'(out_valid), 32'd0);

        pr = {4'd9, 4'd7, 4'd2, 4'd5};
        pi = {2'd3, 2'd2, 2'd1, 2'd0};
        send(pr, pi, acc);
        in_valid = 1'b0;
        check("ord_err", 32'(err), 32'd1);
        check("ord_no_valid", 32'(out_valid), 32'd0);
        @(posedge clk);
        #1;
        check("ord_err_clear", 32'(err), 32'd0);

        // Bad tuple at the handoff: the old tuple still completes.
        send(basic.r, basic.ix, acc);
        push4(basic.e);
        send(pr, pi, acc);
        in_valid = 1'b0;
        check("handoff_err", 32'(err), 32'd1);
        check("handoff_idle", 32'(out_valid), 32'd0);
        drain();
`else
        // Duplicate indices: rb overwrites ra at position 0, position 1 keeps 9.
        pi = {2'd3, 2'd2, 2'd0, 2'd0};
        pe = {4'd9, 4'd7, 4'd9, 4'd3};
        send(basic.r, pi, acc);
        push4(pe);
        in_valid = 1'b0;
        check("nochk_err", 32'(err), 32'd0);
        check("nochk_valid", 32'(out_valid), 32'd1);
        drain();
        check("nochk_err_end", 32'(err), 32'd0);
`endif

        // Reset in the middle of a tuple.
        send(basic.r, basic.ix, acc);
        push4(basic.e);
        in_valid = 1'b0;
        @(posedge clk);
        #1;
        @(posedge clk);
        #1;
        check("mid_cnt2", 32'(out_idx), 32'd2);
        rst_n = 1'b0;
        q.delete();
        #1;
        check("mid_rst_valid", 32'(out_valid), 32'd0);
        check("mid_rst_in_ready", 32'(in_ready), 32'd0);
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        @(posedge clk);
        #1;
        check("mid_in_ready", 32'(in_ready), 32'd1);
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            check("mid_no_output", 32'(out_valid), 32'd0);
        end
        @(posedge clk);
        #1;

        // Random stream: restored order must equal the original order.
        rand_bp = 1'b1;
        for (int t = 0; t < 50; t++) begin
            for (int k = 0; k < 4; k++) begin
                orig[k] = 4'($urandom % 15);
                v[k]    = orig[k];
                vi[k]   = 2'(k);
            end
            for (int a = 0; a < 3; a++) begin
                for (int b = 0; b < 3 - a; b++) begin
                    if (v[b] > v[b + 1]) begin
                        tv = v[b]; v[b] = v[b + 1]; v[b + 1] = tv;
                        ti = vi[b]; vi[b] = vi[b + 1]; vi[b + 1] = ti;
                    end
                end
            end
            for (int k = 0; k < 4; k++) begin
                pr[k] = v[k];
                pi[k] = vi[k];
                pe[k] = orig[k];
            end
            send(pr, pi, acc);
            push4(pe);
        end
        in_valid = 1'b0;
        drain();
        rand_bp = 1'b0;
        @(posedge clk);
        #2;
        out_ready = 1'b1;
        repeat (2) @(posedge clk);

        $display("== %0d vectors applied, %0d miscompares ==", nvec, nerr);
        $finish;
    end

endmodule
